// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory stage: writeback source select, load/store
// size codes and the memory-access FSM state type.
package mem_stage_lsu_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for the data-memory port: store replication and strobes,
// load extraction with sign/zero extension, and misalignment detection.
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [1:0]  size;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        sign_ext;

    always_comb begin
        // Stores have no unsigned variants, so funct3[2] set on a store is undefined and falls back to a word.
        size      = (is_store && funct3[2]) ? 2'b10 : funct3[1:0];
        sign_ext  = ~funct3[2];
        sel_byte  = rdata[{offset, 3'b000} +: 8];
        sel_half  = offset[1] ? rdata[31:16] : rdata[15:0];
        wdata     = store_data;
        wstrb     = 4'b1111;
        load_data = rdata;
        misalign  = 1'b0;
        case (size)
            2'b00: begin
                wdata     = {4{store_data[7:0]}};
                wstrb     = 4'b0001 << offset;
                load_data = {{24{sel_byte[7] & sign_ext}}, sel_byte};
            end
            2'b01: begin
                wdata     = {2{store_data[15:0]}};
                wstrb     = 4'b0011 << offset;
                load_data = {{16{sel_half[15] & sign_ext}}, sel_half};
                misalign  = offset[0];
            end
            default: begin
                misalign = |offset;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage of the RV32I pipeline: owns EX/MEM and MEM/WB registers, runs
// loads/stores over a valid/ready data port and stalls while an access is pending.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   ALUResultE,
    input  logic [XLEN-1:0]   WriteDataE,
    input  logic [2:0]        funct3E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic [XLEN-1:0]   PCPlus4E,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [REG_AW-1:0] RdM,
    output logic              RegWriteM,
    output logic              StallM,
    output logic              MisalignM,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [XLEN-1:0]   PCPlus4W,
    output logic [REG_AW-1:0] RdW,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [XLEN-1:0]   dmem_req_addr,
    output logic [XLEN-1:0]   dmem_req_wdata,
    output logic [3:0]        dmem_req_wstrb,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rsp_rdata,
    output lsu_state_t        fsm_state
);

    // Request/response contract: a request transfers on the cycle both
    // dmem_req_valid and dmem_req_ready are high; once raised, valid and all
    // request fields hold until that transfer. dmem_rsp_valid is a one-cycle
    // pulse carrying the read word and is only honoured while in ST_RSP.

    logic [XLEN-1:0]   alu_m;
    logic [XLEN-1:0]   store_data_m;
    logic [XLEN-1:0]   pc4_m;
    logic [2:0]        funct3_m;
    logic [REG_AW-1:0] rd_m;
    logic              reg_write_m;
    logic              mem_write_m;
    logic [1:0]        result_src_m;

    lsu_state_t state;
    lsu_state_t state_next;

    logic        is_load;
    logic        mem_op;
    logic        misalign;
    logic        aligned_op;
    logic        done;
    logic [31:0] wdata_lane;
    logic [3:0]  wstrb_lane;
    logic [31:0] load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_m        <= '0;
            store_data_m <= '0;
            pc4_m        <= '0;
            funct3_m     <= '0;
            rd_m         <= '0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= RES_ALU;
        end else if (!StallM) begin
            alu_m        <= ALUResultE;
            store_data_m <= WriteDataE;
            pc4_m        <= PCPlus4E;
            funct3_m     <= funct3E;
            rd_m         <= RdE;
            reg_write_m  <= RegWriteE;
            mem_write_m  <= MemWriteE;
            result_src_m <= ResultSrcE;
        end
    end

    mem_stage_lsu_align u_align (
        .offset     (alu_m[1:0]),
        .funct3     (funct3_m),
        .is_store   (mem_write_m),
        .store_data (store_data_m),
        .rdata      (dmem_rsp_rdata),
        .wdata      (wdata_lane),
        .wstrb      (wstrb_lane),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    assign is_load    = ~mem_write_m & (result_src_m == RES_MEM);
    assign mem_op     = mem_write_m | (result_src_m == RES_MEM);
    assign aligned_op = mem_op & ~misalign;
    assign MisalignM  = mem_op & misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next     = state;
        dmem_req_valid = 1'b0;
        done           = 1'b0;
        case (state)
            ST_IDLE, ST_REQ: begin
                if (aligned_op) begin
                    dmem_req_valid = 1'b1;
                    if (dmem_req_ready) begin
                        if (mem_write_m) begin
                            done       = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            state_next = ST_RSP;
                        end
                    end else begin
                        state_next = ST_REQ;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RSP: begin
                if (dmem_rsp_valid) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        StallM = aligned_op & ~done;
    end

    // Request fields are zero whenever no request is offered.
    assign dmem_req_we    = dmem_req_valid & mem_write_m;
    assign dmem_req_addr  = dmem_req_valid ? {alu_m[XLEN-1:2], 2'b00} : '0;
    assign dmem_req_wdata = dmem_req_valid ? wdata_lane : '0;
    assign dmem_req_wstrb = dmem_req_valid ? wstrb_lane : 4'b0000;

    assign ALUResultM = alu_m;
    assign RdM        = rd_m;
    assign RegWriteM  = reg_write_m;
    assign fsm_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= RES_ALU;
        end else if (StallM) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= RES_ALU;
        end else begin
            ALUResultW <= alu_m;
            ReadDataW  <= is_load ? load_data : '0;
            PCPlus4W   <= pc4_m;
            RdW        <= rd_m;
            RegWriteW  <= reg_write_m & ~MisalignM;
            ResultSrcW <= result_src_m;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: transaction-level model of requests and
// writebacks, a per-cycle compare process, and literal pins on key results.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ALUResultE = '0, WriteDataE = '0, PCPlus4E = '0;
    logic [2:0]  funct3E = '0;
    logic [4:0]  RdE = '0;
    logic        RegWriteE = 1'b0, MemWriteE = 1'b0;
    logic [1:0]  ResultSrcE = '0;
    logic [31:0] ALUResultM, ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdM, RdW;
    logic        RegWriteM, StallM, MisalignM, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic        dmem_req_valid, dmem_req_we;
    logic        dmem_req_ready = 1'b0, dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic [31:0] dmem_rsp_rdata = '0;
    lsu_state_t  fsm_state;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .funct3E(funct3E),
        .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .PCPlus4E(PCPlus4E),
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .StallM(StallM), .MisalignM(MisalignM),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
        .fsm_state(fsm_state)
    );

    // Clock/reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int stall_cnt = 0, mis_cnt = 0, valid_cnt = 0;
    logic [31:0] pc_next = 32'h0000_1000;
    logic [31:0] last_addr = '0, last_wdata = '0, last_rdw = '0;
    logic [3:0]  last_wstrb = '0;

    // Scoreboard: {we, wstrb, addr, wdata} and {rd, rsrc, alu, pc4, rdata}
    logic [68:0]  exp_req_q[$];
    logic [102:0] exp_wb_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    // Model: access size in bytes from funct3
    function automatic int op_size(input logic [2:0] f3, input logic is_store);
        if (is_store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [2:0] f3);
        int sz;
        logic [31:0] v, mask;
        sz = op_size(f3, 1'b0);
        if (sz == 4) return word;
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (word >> (8 * addr[1:0])) & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [35:0] model_store(input logic [31:0] addr, input logic [31:0] rs2,
                                                input logic [2:0] f3);
        int sz;
        logic [31:0] mask, wd;
        logic [3:0]  strb;
        sz = op_size(f3, 1'b1);
        if (sz == 4) return {4'hF, rs2};
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        wd = '0;
        for (int i = 0; i < 4; i += sz) wd = wd | ((rs2 & mask) << (8 * i));
        strb = 4'((1 << sz) - 1) << addr[1:0];
        return {strb, wd};
    endfunction

    // Compare process
    logic        pend = 1'b0;
    logic        prev_stall = 1'b0;
    logic [68:0] held = '0;
    always @(negedge clk) begin
        logic [68:0]  cur, er;
        logic [102:0] ew;
        if (!rst_n) begin
            pend = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (StallM) stall_cnt++;
            if (MisalignM) mis_cnt++;
            if (prev_stall) begin
                check("bubble_regwrite", RegWriteW, 1'b0);
                check("bubble_rd", RdW, 5'd0);
            end
            cur = {dmem_req_we, dmem_req_wstrb, dmem_req_addr, dmem_req_wdata};
            if (pend) check("req_held_stable", {dmem_req_valid, cur}, {1'b1, held});
            if (dmem_req_valid) begin
                valid_cnt++;
                if (dmem_req_ready) begin
                    if (exp_req_q.size() == 0) flag_fail("req_unexpected");
                    else begin
                        er = exp_req_q.pop_front();
                        check("req_we", dmem_req_we, er[68]);
                        check("req_addr", dmem_req_addr, er[63:32]);
                        if (er[68]) begin
                            check("req_wstrb", dmem_req_wstrb, er[67:64]);
                            check("req_wdata", dmem_req_wdata, er[31:0]);
                        end
                    end
                    last_addr = dmem_req_addr;
                    last_wdata = dmem_req_wdata;
                    last_wstrb = dmem_req_wstrb;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    held = cur;
                end
            end else begin
                pend = 1'b0;
            end
            if (RegWriteW) begin
                if (exp_wb_q.size() == 0) flag_fail("wb_unexpected");
                else begin
                    ew = exp_wb_q.pop_front();
                    check("wb_rd", RdW, ew[102:98]);
                    check("wb_rsrc", ResultSrcW, ew[97:96]);
                    check("wb_alu", ALUResultW, ew[95:64]);
                    check("wb_pc4", PCPlus4W, ew[63:32]);
                    if (ew[97:96] == RES_MEM) check("wb_rdata", ReadDataW, ew[31:0]);
                end
                last_rdw = ReadDataW;
            end
            prev_stall = StallM;
        end
    end

    // Driver: one instruction through M with a fixed memory schedule
    task automatic run_op(input string tag, input logic is_store, input logic [1:0] rsrc,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [4:0] rd, input int r_dly, input int d_dly,
                          input logic [31:0] rdata, input logic spur);
        logic mem, mis, rw;
        int sz, n;
        logic [35:0] st;
        logic [31:0] pc4;
        pc4 = pc_next;
        pc_next += 4;
        mem = is_store || (rsrc == RES_MEM);
        sz = op_size(f3, is_store);
        mis = mem && ((int'(addr[1:0]) % sz) != 0);
        rw = !is_store;
        n = (!mem || mis) ? 0 : (is_store ? r_dly : r_dly + d_dly);
        if (mem && !mis) begin
            st = model_store(addr, rs2, f3);
            exp_req_q.push_back({is_store, st[35:32], {addr[31:2], 2'b00}, st[31:0]});
        end
        if (rw && !mis)
            exp_wb_q.push_back({rd, rsrc, addr, pc4,
                                (rsrc == RES_MEM) ? model_load(rdata, addr, f3) : 32'h0});
        ALUResultE = addr; WriteDataE = rs2; funct3E = f3; RdE = rd;
        RegWriteE = rw; MemWriteE = is_store; ResultSrcE = rsrc; PCPlus4E = pc4;
        stall_cnt = 0; mis_cnt = 0; valid_cnt = 0;
        @(posedge clk); #1;
        for (int c = 0; c <= n; c++) begin
            if (c == 0) begin
                check({tag, "_alu_m"}, ALUResultM, addr);
                check({tag, "_rd_m"}, RdM, rd);
                check({tag, "_regwrite_m"}, RegWriteM, rw);
                ALUResultE = '0; WriteDataE = '0; funct3E = '0; RdE = '0;
                RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = RES_ALU; PCPlus4E = '0;
            end
            dmem_req_ready = (c >= r_dly);
            dmem_rsp_valid = (mem && !mis && !is_store && c == r_dly + d_dly) || (spur && c < r_dly);
            dmem_rsp_rdata = (c == r_dly + d_dly) ? rdata : 32'hBAD0_BAD0;
            @(posedge clk); #1;
        end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = '0;
        @(posedge clk); #1;
        check({tag, "_stall_cycles"}, stall_cnt, n);
        check({tag, "_misalign_cycles"}, mis_cnt, mis);
        check({tag, "_req_cycles"}, valid_cnt, (mem && !mis) ? r_dly + 1 : 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", StallM, 1'b0);
        check("rst_req_valid", dmem_req_valid, 1'b0);
        check("rst_req_fields", {dmem_req_we, dmem_req_wstrb, dmem_req_addr, dmem_req_wdata}, '0);
        check("rst_m", {ALUResultM, RdM, RegWriteM, MisalignM}, '0);
        check("rst_w", {ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW}, '0);
        check("rst_state", fsm_state, ST_IDLE);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("alu", 1'b0, RES_ALU, F3_W, 32'h1234_5678, 32'h0, 5'd3, 0, 0, 32'h0, 1'b0);
        run_op("sw", 1'b1, RES_ALU, F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'h0, 1'b0);
        check("sw_addr_lit", last_addr, 32'h0000_0100);
        check("sw_wdata_lit", last_wdata, 32'hDEAD_BEEF);
        check("sw_wstrb_lit", last_wstrb, 4'b1111);
        run_op("sb", 1'b1, RES_ALU, F3_B, 32'h0000_0103, 32'h0000_00A5, 5'd0, 0, 0, 32'h0, 1'b0);
        check("sb_addr_lit", last_addr, 32'h0000_0100);
        check("sb_wdata_lit", last_wdata, 32'hA5A5_A5A5);
        check("sb_wstrb_lit", last_wstrb, 4'b1000);
        run_op("sh", 1'b1, RES_ALU, F3_H, 32'h0000_0102, 32'h1234_BEEF, 5'd0, 2, 0, 32'h0, 1'b0);
        check("sh_wdata_lit", last_wdata, 32'hBEEF_BEEF);
        check("sh_wstrb_lit", last_wstrb, 4'b1100);

        run_op("lb", 1'b0, RES_MEM, F3_B, 32'h0000_0102, 32'h0, 5'd5, 0, 1, 32'h80FF_1234, 1'b0);
        check("lb_lit", last_rdw, 32'hFFFF_FFFF);
        run_op("lbu", 1'b0, RES_MEM, F3_BU, 32'h0000_0102, 32'h0, 5'd6, 0, 1, 32'h80FF_1234, 1'b0);
        check("lbu_lit", last_rdw, 32'h0000_00FF);
        run_op("lh", 1'b0, RES_MEM, F3_H, 32'h0000_0102, 32'h0, 5'd7, 0, 1, 32'h80FF_1234, 1'b0);
        check("lh_lit", last_rdw, 32'hFFFF_80FF);
        run_op("lhu", 1'b0, RES_MEM, F3_HU, 32'h0000_0100, 32'h0, 5'd8, 1, 1, 32'h80FF_1234, 1'b1);
        check("lhu_lit", last_rdw, 32'h0000_1234);
        run_op("lw_slow", 1'b0, RES_MEM, F3_W, 32'h0000_0104, 32'h0, 5'd9, 3, 2, 32'hCAFE_F00D, 1'b1);
        check("lw_slow_lit", last_rdw, 32'hCAFE_F00D);

        run_op("lw_mis", 1'b0, RES_MEM, F3_W, 32'h0000_0101, 32'h0, 5'd10, 0, 1, 32'h1111_1111, 1'b0);
        run_op("sh_mis", 1'b1, RES_ALU, F3_H, 32'h0000_0103, 32'h5555_AAAA, 5'd0, 0, 0, 32'h0, 1'b0);
        run_op("lh_ok_odd_word", 1'b0, RES_MEM, F3_HU, 32'h0000_0206, 32'h0, 5'd11, 0, 1, 32'h9ABC_0000, 1'b0);
        run_op("pc4", 1'b0, RES_PC4, F3_W, 32'h0000_0ABC, 32'h0, 5'd12, 0, 0, 32'h0, 1'b0);

        // Reset while the load waits for its response
        exp_req_q.push_back({1'b0, 4'h0, 32'h0000_0200, 32'h0});
        ALUResultE = 32'h0000_0200; ResultSrcE = RES_MEM; funct3E = F3_W; RdE = 5'd13;
        RegWriteE = 1'b1; MemWriteE = 1'b0; PCPlus4E = pc_next; WriteDataE = '0;
        pc_next += 4;
        @(posedge clk); #1;
        ALUResultE = '0; ResultSrcE = RES_ALU; funct3E = '0; RdE = '0; RegWriteE = 1'b0; PCPlus4E = '0;
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        check("rstmid_pre_state", fsm_state, ST_RSP);
        check("rstmid_pre_stall", StallM, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstmid_stall", StallM, 1'b0);
        check("rstmid_req_valid", dmem_req_valid, 1'b0);
        check("rstmid_m", {ALUResultM, RdM, RegWriteM, MisalignM}, '0);
        check("rstmid_w", {ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW}, '0);
        check("rstmid_state", fsm_state, ST_IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hFFFF_0000;
        #1;
        check("rstmid_late_rsp_stall", StallM, 1'b0);
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        check("rstmid_late_rsp_state", fsm_state, ST_IDLE);
        check("rstmid_late_rsp_regwrite", RegWriteW, 1'b0);
        run_op("sw_after_rst", 1'b1, RES_ALU, F3_W, 32'h0000_0300, 32'h0BAD_F00D, 5'd0, 0, 0, 32'h0, 1'b0);
        run_op("lw_after_rst", 1'b0, RES_MEM, F3_W, 32'h0000_0304, 32'h0, 5'd14, 1, 1, 32'h7654_3210, 1'b0);
        check("lw_after_rst_lit", last_rdw, 32'h7654_3210);

        repeat (2) @(posedge clk);
        check("req_queue_drained", exp_req_q.size(), 0);
        check("wb_queue_drained", exp_wb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage block of the 5-stage RV32I pipeline.
- Consumes the execute-stage results (ALU result, forwarded store data, funct3, control) through the EX/MEM pipeline register it owns.
- Performs loads/stores over a valid/ready data-memory port and presents MEM-stage forwarding values plus MEM/WB register contents to writeback.
- Generates the pipeline stall while a memory access is outstanding.

Parameters:
XLEN, 32, datapath width (only 32 supported)
REG_AW, 5, register-index width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
ALUResultE  in  XLEN  EX result / effective address
WriteDataE  in  XLEN  forwarded rs2 for stores
funct3E  in  3  load/store size and sign
RdE  in  REG_AW  destination register
RegWriteE  in  1  register write enable
MemWriteE  in  1  store
ResultSrcE  in  2  00 ALU, 01 load, 10 PC+4, 11 imm
PCPlus4E  in  XLEN  link value
ALUResultM  out  XLEN  forwarding value to EX
RdM  out  REG_AW  to hazard unit
RegWriteM  out  1  to hazard unit
StallM  out  1  freeze IF/ID/EX and EX/MEM
MisalignM  out  1  one-cycle misaligned-access flag
ALUResultW, ReadDataW, PCPlus4W  out  XLEN  MEM/WB register
RdW  out  REG_AW  MEM/WB register
RegWriteW  out  1  MEM/WB register
ResultSrcW  out  2  MEM/WB register
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_req_we  out  1  1 = store
dmem_req_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
dmem_req_wdata  out  XLEN  lane-shifted store data
dmem_req_wstrb  out  4  byte strobes
dmem_rsp_valid  in  1  load data valid
dmem_rsp_rdata  in  XLEN  raw word

Behaviour:
- Reset: clk, rst_n; asynchronous active-low. All EX/MEM and MEM/WB registers cleared to 0 (bubble). FSM goes to IDLE. All outputs 0.
- EX/MEM register: loads E inputs on posedge when StallM=0 and holds when StallM=1.
- MEM op: MemWriteM=1 (store) or ResultSrcM=01 (load).
- Alignment:
  - Misaligned: halfword ops with addr[0]=1; word ops with addr[1:0]!=0.
  - Response: MisalignM=1 for that cycle, no request issued, no stall, RegWriteW forced to 0.
- FSM states: IDLE, REQ, RSP.
  - IDLE with aligned MEM op: dmem_req_valid=1.
    - Handshake with a store: operation complete and stays IDLE.
    - Handshake with a load: go to RSP.
    - No handshake: go to REQ.
  - REQ: dmem_req_valid=1. Request fields are stable (driven from held EX/MEM regs). On handshake: store completes and returns to IDLE; load goes to RSP.
  - RSP: dmem_req_valid=0. On dmem_rsp_valid, load completes and returns to IDLE.
- StallM: 1 whenever an aligned MEM op is in M and not completing this cycle. Combinational from the FSM, handshake and rsp_valid.
- Latency:
  - Store with ready=1: 0 stall cycles.
  - Load: at least 1 stall cycle (response arrives no earlier than the cycle after the handshake).
- MEM/WB register:
  - Advances every cycle.
  - While StallM=1 it captures a bubble (RegWriteW=0, RdW=0).
  - On completion or non-MEM op it captures the M contents.
  - ReadDataW is the extended load data.
- Store lanes (o = addr[1:0]):
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 1<<o.
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011<<o.
  - SW: wdata = rs2, wstrb = 1111.
- Load extract:
  - LB/LBU: byte o, sign/zero-extended.
  - LH/LHU: halfword o[1], sign/zero-extended.
  - LW: full word.
  - Undefined funct3: treated as LW/SW.
- Spurious dmem_rsp_valid outside RSP: ignored.
- Reset mid-operation: FSM returns to IDLE, request dropped, any later response ignored.

Decomposition:
- Shared package holds:
  - ResultSrc encodings (RES_ALU=00, RES_MEM=01, RES_PC4=10, RES_IMM=11).
  - funct3 load/store codes (F3_B/H/W/BU/HU).
  - FSM state typedef.
- One natural combinational sub-module: lsu_align, covering store lane/strobe generation, load extract/extension and misalignment detection.

Test Plan:
- SW ALUResultE=0x100, WriteDataE=0xDEADBEEF, ready=1 -> one-cycle req: addr 0x100, wdata 0xDEADBEEF, wstrb 1111, we=1, StallM=0.
- SB addr 0x103, data 0x000000A5 -> wdata 0xA5A5A5A5, wstrb 1000, addr 0x100.
- Loads with rdata 0x80FF1234 returned one cycle after the handshake:
  - LB at 0x102 -> ReadDataW 0xFFFFFFFF.
  - LBU at 0x102 -> 0x000000FF.
  - LH at 0x102 -> 0xFFFF80FF.
  - Each load: StallM high exactly 1 cycle, RegWriteW=1 in the completion cycle.
- LW with ready low for 3 cycles, then rsp after 2 more -> StallM high 5 cycles, req fields constant while valid, exactly one bubble in W per stall cycle.
- LW addr 0x101 -> MisalignM=1 for 1 cycle, dmem_req_valid never asserted, StallM=0, RegWriteW=0.
- rst_n low during RSP, then rsp_valid -> all outputs 0, FSM IDLE, response ignored, next instruction issues normally.
